// File: rtl/logic_op_sequencer.sv
// logic_op_sequencer: accepts logic-unit commands, drives registered operands,
// waits a settle time, captures the result and returns it over valid/ready.
`default_nettype none

module logic_op_sequencer #(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [1:0]       i_cmd_op,
   input  logic [3:0]       i_cmd_a,
   input  logic [3:0]       i_cmd_b,
   input  logic [7:0]       i_cmd_c,
   output logic [3:0]       o_lu_a,
   output logic [3:0]       o_lu_b,
   output logic [7:0]       o_lu_c,
   output logic [1:0]       o_lu_sw,
   input  logic [7:0]       i_lu_f,
   output logic             o_res_valid,
   input  logic             i_res_ready,
   output logic [7:0]       o_res_data,
   output logic [1:0]       o_res_op,
   output logic [CNT_W-1:0] o_op_count
);

   localparam int             c_CW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [c_CW-1:0] c_LOAD = c_CW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_HOLD   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              w_accept;
   logic              w_capture;
   logic              w_done;
   logic [c_CW-1:0]   r_cnt;
   logic [3:0]        r_lu_a;
   logic [3:0]        r_lu_b;
   logic [7:0]        r_lu_c;
   logic [1:0]        r_lu_sw;
   logic              r_res_valid;
   logic [7:0]        r_res_data;
   logic [1:0]        r_res_op;
   logic [CNT_W-1:0]  r_op_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_done      = 1'b0;
      o_cmd_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_cmd_ready = 1'b1;
            if (i_cmd_valid) begin
               w_accept = 1'b1;
               w_next   = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (r_cnt == '0) begin
               w_capture = 1'b1;
               w_next    = S_HOLD;
            end
         end
         S_HOLD: begin
            // r_res_valid is always set here, so ready alone completes the handshake.
            if (r_res_valid && i_res_ready) begin
               w_done = 1'b1;
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_lu_a      <= '0;
         r_lu_b      <= '0;
         r_lu_c      <= '0;
         r_lu_sw     <= '0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_op    <= '0;
         r_op_count  <= '0;
      end else begin
         if (w_accept) begin
            r_lu_a  <= i_cmd_a;
            r_lu_b  <= i_cmd_b;
            r_lu_c  <= i_cmd_c;
            r_lu_sw <= i_cmd_op;
            r_cnt   <= c_LOAD;
         end else if (r_state == S_SETTLE && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_capture) begin
            r_res_data  <= i_lu_f;
            r_res_op    <= r_lu_sw;
            r_res_valid <= 1'b1;
         end else if (w_done) begin
            r_res_valid <= 1'b0;
            r_op_count  <= r_op_count + 1'b1;
         end
      end
   end

   assign o_lu_a      = r_lu_a;
   assign o_lu_b      = r_lu_b;
   assign o_lu_c      = r_lu_c;
   assign o_lu_sw     = r_lu_sw;
   assign o_res_valid = r_res_valid;
   assign o_res_data  = r_res_data;
   assign o_res_op    = r_res_op;
   assign o_op_count  = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_logic_op_sequencer.sv
// Bench for logic_op_sequencer: two instances (settle 1 / 8-bit count and
// settle 3 / 2-bit count) driven by directed and random ops against a model.
`default_nettype none

module tb_logic_op_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid [2];
   logic       cmd_ready [2];
   logic [1:0] cmd_op    [2];
   logic [3:0] cmd_a     [2];
   logic [3:0] cmd_b     [2];
   logic [7:0] cmd_c     [2];
   logic [3:0] lu_a      [2];
   logic [3:0] lu_b      [2];
   logic [7:0] lu_c      [2];
   logic [1:0] lu_sw     [2];
   logic [7:0] lu_f      [2];
   logic [7:0] pert      [2];
   logic       res_valid [2];
   logic       res_ready [2];
   logic [7:0] res_data  [2];
   logic [1:0] res_op    [2];
   logic [7:0] oc0;
   logic [1:0] oc1;

   int n_checks = 0;
   int n_errors = 0;
   int settle [2] = '{1, 3};
   int modulo [2] = '{256, 4};
   int count  [2] = '{0, 0};

   always #5 clk = ~clk;

   function automatic logic [7:0] ref_f(input logic [1:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [7:0] c);
      case (op)
         2'd0:    return {4'h0, a & b};
         2'd1:    return {4'h0, a | b};
         2'd2:    return {4'h0, a ^ b};
         default: return ~c;
      endcase
   endfunction

   // Emulated combinational logic unit, with an optional disturbance term.
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         lu_f[k] = ref_f(lu_sw[k], lu_a[k], lu_b[k], lu_c[k]) ^ pert[k];
      end
   end

   logic_op_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) u_dut0 (
      .clk(clk), .rst(rst),
      .i_cmd_valid(cmd_valid[0]), .o_cmd_ready(cmd_ready[0]),
      .i_cmd_op(cmd_op[0]), .i_cmd_a(cmd_a[0]), .i_cmd_b(cmd_b[0]), .i_cmd_c(cmd_c[0]),
      .o_lu_a(lu_a[0]), .o_lu_b(lu_b[0]), .o_lu_c(lu_c[0]), .o_lu_sw(lu_sw[0]),
      .i_lu_f(lu_f[0]),
      .o_res_valid(res_valid[0]), .i_res_ready(res_ready[0]),
      .o_res_data(res_data[0]), .o_res_op(res_op[0]), .o_op_count(oc0)
   );

   logic_op_sequencer #(.SETTLE_CYCLES(3), .CNT_W(2)) u_dut1 (
      .clk(clk), .rst(rst),
      .i_cmd_valid(cmd_valid[1]), .o_cmd_ready(cmd_ready[1]),
      .i_cmd_op(cmd_op[1]), .i_cmd_a(cmd_a[1]), .i_cmd_b(cmd_b[1]), .i_cmd_c(cmd_c[1]),
      .o_lu_a(lu_a[1]), .o_lu_b(lu_b[1]), .o_lu_c(lu_c[1]), .o_lu_sw(lu_sw[1]),
      .i_lu_f(lu_f[1]),
      .o_res_valid(res_valid[1]), .i_res_ready(res_ready[1]),
      .o_res_data(res_data[1]), .o_res_op(res_op[1]), .o_op_count(oc1)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int get_cnt(input int k);
      return (k == 0) ? int'(oc0) : int'(oc1);
   endfunction

   // One complete op on instance k; hold = cycles res_ready stays low while
   // a competing command is offered; pert_at = settle edge at which lu_f is disturbed.
   task automatic do_op(input int k, input logic [1:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [7:0] c, input int hold,
                        input int pert_at, input logic [7:0] pv);
      logic [7:0] exp;
      int         n;
      @(negedge clk);
      cmd_valid[k] = 1'b1; cmd_op[k] = op; cmd_a[k] = a; cmd_b[k] = b; cmd_c[k] = c;
      res_ready[k] = 1'b0;
      check("cmd_ready_idle", cmd_ready[k], 1);
      @(negedge clk);
      cmd_valid[k] = (hold > 0);
      cmd_op[k] = 2'($urandom); cmd_a[k] = 4'($urandom); cmd_b[k] = 4'($urandom);
      cmd_c[k] = 8'($urandom);
      check("cmd_ready_busy", cmd_ready[k], 0);
      exp = ref_f(op, a, b, c) ^ ((pert_at >= 0) ? pv : 8'h00);
      n = 0;
      while (res_valid[k] !== 1'b1 && n < 20) begin
         check("lu_a_stable", lu_a[k], a);
         check("lu_b_stable", lu_b[k], b);
         check("lu_c_stable", lu_c[k], c);
         check("lu_sw_stable", lu_sw[k], op);
         @(negedge clk);
         n++;
         if (n == pert_at) pert[k] = pv;
      end
      check("latency", n, settle[k]);
      pert[k] = 8'h00;
      check("res_data", res_data[k], exp);
      check("res_op", res_op[k], op);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_valid", res_valid[k], 1);
         check("hold_data", res_data[k], exp);
         check("hold_cmd_ready", cmd_ready[k], 0);
      end
      cmd_valid[k] = 1'b0;
      res_ready[k] = 1'b1;
      @(negedge clk);
      res_ready[k] = 1'b0;
      count[k] = (count[k] + 1) % modulo[k];
      check("op_count", get_cnt(k), count[k]);
      check("valid_cleared", res_valid[k], 0);
      check("back_to_idle", cmd_ready[k], 1);
      check("lu_a_kept", lu_a[k], a);
      check("lu_sw_kept", lu_sw[k], op);
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         cmd_valid[k] = 1'b0; cmd_op[k] = '0; cmd_a[k] = '0; cmd_b[k] = '0;
         cmd_c[k] = '0; res_ready[k] = 1'b0; pert[k] = 8'h00;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", cmd_ready[0], 1);
      check("rst_res_valid", res_valid[0], 0);
      check("rst_res_data", res_data[0], 0);
      check("rst_lu_c", lu_c[0], 0);
      check("rst_op_count", get_cnt(0), 0);
      rst = 1'b0;

      do_op(0, 2'd0, 4'hC, 4'hA, 8'h00, 0, -1, 8'h00);
      check("and_value", res_data[0], 8'h08);
      do_op(0, 2'd1, 4'hC, 4'hA, 8'h00, 0, -1, 8'h00);
      check("or_value", res_data[0], 8'h0E);
      do_op(0, 2'd2, 4'hC, 4'hA, 8'h00, 0, -1, 8'h00);
      check("xor_value", res_data[0], 8'h06);
      do_op(0, 2'd3, 4'hC, 4'hA, 8'h5A, 0, -1, 8'h00);
      check("not_value", res_data[0], 8'hA5);
      check("count_four", get_cnt(0), 4);

      do_op(0, 2'd1, 4'h5, 4'h3, 8'h11, 10, -1, 8'h00);
      do_op(1, 2'd2, 4'h9, 4'h6, 8'h33, 2, 1, 8'h5C);

      // Reset while instance 1 is mid-settle.
      @(negedge clk);
      cmd_valid[1] = 1'b1; cmd_op[1] = 2'd3; cmd_c[1] = 8'h0F;
      @(negedge clk);
      cmd_valid[1] = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_cmd_ready", cmd_ready[1], 1);
      check("arst_lu_c", lu_c[1], 0);
      check("arst_lu_sw", lu_sw[1], 0);
      check("arst_res_valid", res_valid[1], 0);
      check("arst_op_count", get_cnt(1), 0);
      check("arst_dut0_count", get_cnt(0), 0);
      count[0] = 0; count[1] = 0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("post_rst_no_valid", res_valid[1], 0);
      end
      check("post_rst_count", get_cnt(1), 0);

      // Five ops on the 2-bit counter: 1,2,3,0,1.
      for (int i = 0; i < 5; i++) begin
         do_op(1, 2'($urandom), 4'($urandom), 4'($urandom), 8'($urandom), 0, -1, 8'h00);
      end
      check("wrap_final", get_cnt(1), 1);

      for (int i = 0; i < 40; i++) begin
         do_op(int'($urandom_range(1, 0)), 2'($urandom), 4'($urandom), 4'($urandom),
               8'($urandom), int'($urandom_range(3, 0)), -1, 8'h00);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
